// File: rtl/part_7_if.sv
// Operand, cascade and result signals of one 4-bit comparator slice.
interface part_7_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       firstE;
  logic       firstL;
  logic       firstG;
  logic       E;
  logic       L;
  logic       G;
  logic       outE;
  logic       outL;
  logic       outG;

  // Drives operands and cascade flags, observes results.
  modport master (
    output a, b, firstE, firstL, firstG,
    input  E, L, G, outE, outL, outG
  );

  // The comparator slice itself.
  modport slave (
    input  a, b, firstE, firstL, firstG,
    output E, L, G, outE, outL, outG
  );
endinterface

// File: rtl/part_7.sv
// Clocked 4-bit magnitude comparator slice with cascade inputs.
// A free-running LOAD -> 4x CMP -> DONE sequence compares the captured
// operands MSB first. The first differing bit decides the result.
module part_7 (
  input  logic        clk,
  input  logic        rst,
  part_7_if.slave     bus
);

  typedef enum logic [1:0] {
    LOAD,
    CMP,
    DONE
  } state_t;

  state_t     state_q;
  logic [3:0] ra_q;
  logic [3:0] rb_q;
  logic       rfE_q;
  logic       rfL_q;
  logic       rfG_q;
  logic [1:0] idx_q;
  logic       dec_q;
  logic       lt_q;
  logic       E_q;
  logic       L_q;
  logic       G_q;
  logic       outE_q;
  logic       outL_q;
  logic       outG_q;

  // Control FSM, bit-serial datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      ra_q    <= '0;
      rb_q    <= '0;
      rfE_q   <= 1'b0;
      rfL_q   <= 1'b0;
      rfG_q   <= 1'b0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      lt_q    <= 1'b0;
      E_q     <= 1'b0;
      L_q     <= 1'b0;
      G_q     <= 1'b0;
      outE_q  <= 1'b0;
      outL_q  <= 1'b0;
      outG_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          ra_q    <= bus.a;
          rb_q    <= bus.b;
          rfE_q   <= bus.firstE;
          rfL_q   <= bus.firstL;
          rfG_q   <= bus.firstG;
          dec_q   <= 1'b0;
          lt_q    <= 1'b0;
          idx_q   <= 2'd3;
          state_q <= CMP;
        end
        CMP: begin
          // Only the most significant differing bit may set the decision.
          if (!dec_q && (ra_q[idx_q] != rb_q[idx_q])) begin
            dec_q <= 1'b1;
            lt_q  <= rb_q[idx_q];
          end
          idx_q <= idx_q - 2'd1;
          if (idx_q == 2'd0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!dec_q) begin
            E_q    <= 1'b1;
            L_q    <= 1'b0;
            G_q    <= 1'b0;
            // Equal operands defer to the less-significant slice, unchecked.
            outE_q <= rfE_q;
            outL_q <= rfL_q;
            outG_q <= rfG_q;
          end else if (lt_q) begin
            E_q    <= 1'b0;
            L_q    <= 1'b1;
            G_q    <= 1'b0;
            outE_q <= 1'b0;
            outL_q <= 1'b1;
            outG_q <= 1'b0;
          end else begin
            E_q    <= 1'b0;
            L_q    <= 1'b0;
            G_q    <= 1'b1;
            outE_q <= 1'b0;
            outL_q <= 1'b0;
            outG_q <= 1'b1;
          end
          state_q <= LOAD;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign bus.E    = E_q;
  assign bus.L    = L_q;
  assign bus.G    = G_q;
  assign bus.outE = outE_q;
  assign bus.outL = outL_q;
  assign bus.outG = outG_q;

endmodule

// File: tb/tb_part_7.sv
// Self-checking bench for the part_7 comparator slice.
module tb_part_7;

  logic clk;
  logic rst;
  int unsigned passed;
  int unsigned total;

  part_7_if bus ();

  part_7 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {E,L,G,outE,outL,outG} from plain unsigned comparison.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] f);
    if (a == b)      return {3'b100, f};
    else if (a < b)  return 6'b010_010;
    else             return 6'b001_001;
  endfunction

  function automatic logic [5:0] outs();
    return {bus.E, bus.L, bus.G, bus.outE, bus.outL, bus.outG};
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f);
    bus.a      = a;
    bus.b      = b;
    bus.firstE = f[2];
    bus.firstL = f[1];
    bus.firstG = f[0];
  endtask

  // One full period starting just before a LOAD edge; reports the result
  // after DONE and whether outputs stayed put during the five earlier edges.
  task automatic run_period(input logic [3:0] a, input logic [3:0] b, input logic [2:0] f,
                            output logic [5:0] obs, output bit stable);
    logic [5:0] prev;
    drive(a, b, f);
    prev   = outs();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (outs() !== prev) stable = 1'b0;
    end
    @(posedge clk); #1;
    obs = outs();
  endtask

  task automatic test_reset();
    drive(4'd0, 4'd0, 3'b000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (outs() !== 6'b0) $display("FAIL reset_state: got %b expected %b", outs(), 6'b0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] av [7] = '{4'b1100, 4'b0100, 4'b0100, 4'b0111, 4'b1101, 4'b0011, 4'b0001};
    logic [2:0] fv [7] = '{3'b111, 3'b111, 3'b010, 3'b111, 3'b111, 3'b111, 3'b101};
    logic [5:0] obs;
    logic [5:0] exp;
    bit stable;
    for (int i = 0; i < 7; i++) begin
      run_period(av[i], 4'b0100, fv[i], obs, stable);
      exp = model(av[i], 4'b0100, fv[i]);
      total++;
      if (obs !== exp) $display("FAIL directed_%0d: got %b expected %b", i, obs, exp);
      else passed++;
      total++;
      if (!stable) $display("FAIL directed_stable_%0d: got glitch expected steady outputs", i);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] f;
    logic [5:0] obs;
    logic [5:0] exp;
    bit stable;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom_range(0, 15));
      b = (i % 4 == 0) ? a : 4'($urandom_range(0, 15));
      f = 3'($urandom_range(0, 7));
      run_period(a, b, f, obs, stable);
      exp = model(a, b, f);
      total++;
      if (obs !== exp)
        $display("FAIL random_%0d a=%h b=%h f=%b: got %b expected %b", i, a, b, f, obs, exp);
      else passed++;
      total++;
      if (!stable) $display("FAIL random_stable_%0d: got glitch expected steady outputs", i);
      else passed++;
    end
  endtask

  task automatic test_midcmp_change();
    logic [5:0] obs;
    logic [5:0] exp;
    bit stable;
    drive(4'b0011, 4'b0100, 3'b000);
    @(posedge clk); #1;          // LOAD
    @(posedge clk); #1;          // first CMP
    bus.a = 4'b1001;             // should not affect this period
    repeat (3) @(posedge clk);
    @(posedge clk); #1;          // DONE
    exp = model(4'b0011, 4'b0100, 3'b000);
    total++;
    if (outs() !== exp) $display("FAIL midcmp_old: got %b expected %b", outs(), exp);
    else passed++;
    run_period(4'b1001, 4'b0100, 3'b000, obs, stable);
    exp = model(4'b1001, 4'b0100, 3'b000);
    total++;
    if (obs !== exp) $display("FAIL midcmp_new: got %b expected %b", obs, exp);
    else passed++;
    total++;
    if (!stable) $display("FAIL midcmp_stable: got glitch expected steady outputs");
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [5:0] obs;
    logic [5:0] exp;
    bit stable;
    run_period(4'b1100, 4'b0100, 3'b111, obs, stable);
    total++;
    if (obs !== 6'b001_001) $display("FAIL areset_pre: got %b expected %b", obs, 6'b001_001);
    else passed++;
    drive(4'b1111, 4'b0000, 3'b000);
    @(posedge clk);              // LOAD
    @(posedge clk);              // CMP
    #3;
    rst = 1'b1;                  // between edges
    #1;
    total++;
    if (outs() !== 6'b0) $display("FAIL areset_immediate: got %b expected %b", outs(), 6'b0);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (outs() !== 6'b0) $display("FAIL areset_hold: got %b expected %b", outs(), 6'b0);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_period(4'b0011, 4'b0100, 3'b111, obs, stable);
    exp = model(4'b0011, 4'b0100, 3'b111);
    total++;
    if (obs !== exp) $display("FAIL areset_after: got %b expected %b", obs, exp);
    else passed++;
    total++;
    if (!stable) $display("FAIL areset_after_stable: got glitch expected steady outputs");
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_midcmp_change();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
